// File: rtl/inv_dgl_bank.sv
// ---------------------------------------------------------------------------
// inv_dgl_bank
//
// Multi-channel inverter bank for signals crossing from analog comparators
// into clocked logic. Every channel owns its own input synchroniser and a
// digital deglitch filter. The output of a channel shows the inverse of its
// input only after the synchronised input has differed from the filtered
// state for DGL_CYC consecutive clock edges.
//
// Parameters
//   WIDTH        number of independent channels (1..32)
//   DGL_CYC      consecutive stable edges needed before the output moves (1..255)
//   SYNC_STAGES  synchroniser flops per channel (2..4)
//
// Ports
//   CELCLK   in   1      clock, every state update happens on its rising edge
//   CELRST   in   1      synchronous active-high reset
//   CELV     in   1      supply pin, carried for netlisting only
//   CELG     in   1      ground pin, carried for netlisting only
//   SUB      in   1      substrate pin, carried for netlisting only
//   en       in   1      1 = deglitch active, 0 = bypass filter (sync kept)
//   i        in   WIDTH  asynchronous channel inputs
//   o        out  WIDTH  registered, inverted, filtered outputs
//   busy     out  WIDTH  channel deglitch counter is non-zero
//   chg      out  WIDTH  sticky "output changed" flags      (optional)
//   chg_clr  in   WIDTH  per-channel clear for chg           (optional)
//
// Optional feature
//   Define INVBANK_CHG_FLAG_EN to get the chg / chg_clr ports and the sticky
//   change-flag logic. Without it those ports and the flag logic are absent.
// ---------------------------------------------------------------------------
module inv_dgl_bank #(
  parameter int WIDTH       = 4,
  parameter int DGL_CYC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CELCLK,
  input  logic             CELRST,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
`ifdef INVBANK_CHG_FLAG_EN
  output logic [WIDTH-1:0] chg,
  input  logic [WIDTH-1:0] chg_clr,
`endif
  output logic [WIDTH-1:0] busy
);

  // Counter must hold values 0..DGL_CYC-1; sized from DGL_CYC+1 so that the
  // DGL_CYC=1 case still gets a legal one-bit counter.
  localparam int CNT_W = $clog2(DGL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DGL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] syncOut;

  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Supply, ground and substrate only exist so the symbol matches the
  // schematic-generated netlists; they are folded here and go nowhere.
  logic unusedSupplyPins;
  assign unusedSupplyPins = ^{CELV, CELG, SUB};

  // Input synchroniser: a plain shift chain per channel. The last stage is
  // the only copy of the input that the filter is allowed to look at.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign syncOut = sync_q[SYNC_STAGES-1];

  // Deglitch decision per channel. Any edge on which the synchronised input
  // agrees with the filtered state throws the pending count away, so only an
  // uninterrupted run of DGL_CYC disagreeing edges moves the filtered state.
  // With the filter bypassed the state follows the synchroniser directly and
  // the count is dropped, so re-enabling always starts counting from zero.
  always_comb begin
    filt_d = filt_q;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (!en) begin
        filt_d[n] = syncOut[n];
      end else if (syncOut[n] != filt_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          filt_d[n] = syncOut[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_ONE;
        end
      end
    end
  end

  // The output is a register loaded with the inverse of the next filtered
  // state, so it moves on the same edge as the filtered state itself and
  // never has a combinational path from the filter logic.
  assign o_d = ~filt_d;

  // Filter state, counters and the inverted output register. Reset drops any
  // pending change and parks the outputs high (inverse of a zero state).
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      filt_q <= '0;
      o_q    <= '1;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      o_q    <= o_d;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign o = o_q;

  // Busy simply reports a count in progress; it is derived from the counter
  // register so it updates on the same edge as the count.
  always_comb begin
    busy = '0;
    for (int n = 0; n < WIDTH; n++) begin
      busy[n] = (cnt_q[n] != '0);
    end
  end

`ifdef INVBANK_CHG_FLAG_EN
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;

  // Sticky change flags. A flag is raised on the edge its output toggles and
  // is cleared by chg_clr on the following edge; when a toggle and a clear
  // land on the same edge the new toggle is kept so no event is lost.
  always_comb begin
    chg_d = (chg_q & ~chg_clr) | (o_q ^ o_d);
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;
`else
  // Change flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_inv_dgl_bank.sv
// ---------------------------------------------------------------------------
// tb_inv_dgl_bank
//
// Self-checking bench for inv_dgl_bank at default parameters. A behavioural
// reference model keeps the full history of sampled inputs and enables and
// decides each filter update by looking back over the last DGL_CYC edges.
// Compile with INVBANK_CHG_FLAG_EN defined to also check the change flags.
// ---------------------------------------------------------------------------
module tb_inv_dgl_bank;

  localparam int W    = 4;
  localparam int D    = 8;
  localparam int S    = 2;
  localparam int MAXE = 2048;

  logic         CELCLK = 1'b0;
  logic         CELRST;
  logic         CELV = 1'b1;
  logic         CELG = 1'b0;
  logic         SUB  = 1'b0;
  logic         en;
  logic [W-1:0] i;
  logic [W-1:0] o;
  logic [W-1:0] busy;
`ifdef INVBANK_CHG_FLAG_EN
  logic [W-1:0] chg;
  logic [W-1:0] chg_clr;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: histories indexed by edge number.
  logic [W-1:0] iHist [MAXE];
  logic [W-1:0] sUse  [MAXE];
  bit           enHist[MAXE];
  int           e       = 0;
  int           lastRst = 0;
  logic [W-1:0] fM      = '0;
  logic [W-1:0] busyM   = '0;
  logic [W-1:0] chgM    = '0;

  // Stimulus generator state.
  logic [W-1:0] curI = '0;
  bit           curEn = 1'b1;
  int           holdLeft [W];
  int           enHold = 0;

  always #5 CELCLK = ~CELCLK;

  inv_dgl_bank #(
    .WIDTH      (W),
    .DGL_CYC    (D),
    .SYNC_STAGES(S)
  ) dut (
    .CELCLK (CELCLK),
    .CELRST (CELRST),
    .CELV   (CELV),
    .CELG   (CELG),
    .SUB    (SUB),
    .en     (en),
    .i      (i),
    .o      (o),
`ifdef INVBANK_CHG_FLAG_EN
    .chg    (chg),
    .chg_clr(chg_clr),
`endif
    .busy   (busy)
  );

  // One comparison: count it, report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, e, obs, exp);
    end
  endtask

  // Reference model for one rising edge. The synchronised value seen at edge
  // m is the input sampled S edges earlier (zero if that precedes a reset).
  // With the filter enabled, a channel's state flips at edge m only when the
  // last D edges all had en=1 and a synchronised value opposite to the state.
  task automatic modelEdge(input logic [W-1:0] iIn, input bit enIn, input bit rstIn,
                           input logic [W-1:0] clrIn);
    logic [W-1:0] oldF;
    bit           stable;
    e++;
    iHist[e]  = iIn;
    enHist[e] = enIn;
    if (rstIn) begin
      lastRst = e;
      sUse[e] = '0;
      fM      = '0;
      busyM   = '0;
      chgM    = '0;
    end else begin
      sUse[e] = (e - S > lastRst) ? iHist[e-S] : '0;
      oldF    = fM;
      busyM   = '0;
      for (int n = 0; n < W; n++) begin
        if (!enIn) begin
          fM[n] = sUse[e][n];
        end else if (sUse[e][n] != oldF[n]) begin
          stable = (e - D + 1 > lastRst);
          if (stable) begin
            for (int m = e - D + 1; m <= e; m++) begin
              if (!enHist[m] || sUse[m][n] == oldF[n]) stable = 1'b0;
            end
          end
          if (stable) fM[n] = sUse[e][n];
          else        busyM[n] = 1'b1;
        end
      end
      chgM = (chgM & ~clrIn) | (fM ^ oldF);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare the
  // DUT outputs with the model a little after the edge.
  task automatic applyStimulus(input logic [W-1:0] iIn, input bit enIn, input bit rstIn,
                               input logic [W-1:0] clrIn);
    logic [W-1:0] oExp;
    i      = iIn;
    en     = enIn;
    CELRST = rstIn;
`ifdef INVBANK_CHG_FLAG_EN
    chg_clr = clrIn;
`endif
    @(posedge CELCLK);
    #1;
    modelEdge(iIn, enIn, rstIn, clrIn);
    oExp = ~fM;
    checkOutput("o", o, oExp);
    checkOutput("busy", busy, busyM);
`ifdef INVBANK_CHG_FLAG_EN
    checkOutput("chg", chg, chgM);
`endif
  endtask

  initial begin
    logic [W-1:0] clrNow;
    bit           rstNow;
    i      = '0;
    en     = 1'b1;
    CELRST = 1'b1;
`ifdef INVBANK_CHG_FLAG_EN
    chg_clr = '0;
`endif
    for (int n = 0; n < W; n++) holdLeft[n] = 0;

    // Reset with all inputs high, then release and keep them high.
    repeat (3) applyStimulus(4'hF, 1'b1, 1'b1, '0);
    checkOutput("rstO", o, 32'hF);
    checkOutput("rstBusy", busy, 32'h0);
`ifdef INVBANK_CHG_FLAG_EN
    checkOutput("rstChg", chg, 32'h0);
`endif
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(4'hF, 1'b1, 1'b0, '0);
      if (k == 9)  checkOutput("holdEdge9", o, 32'hF);
      if (k == 10) checkOutput("holdEdge10", o, 32'h0);
    end
    curI = 4'hF;

    // Random run: independent per-channel hold lengths straddling D so both
    // rejected glitches and accepted changes occur; after a while the enable
    // starts toggling, and later reset is pulsed at random points.
    for (int c = 0; c < 1600; c++) begin
      for (int n = 0; n < W; n++) begin
        if (holdLeft[n] == 0) begin
          curI[n]     = ~curI[n];
          holdLeft[n] = int'($urandom_range(1, 12));
        end else begin
          holdLeft[n]--;
        end
      end
      if (c >= 500) begin
        if (enHold == 0) begin
          curEn  = ~curEn;
          enHold = curEn ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 8));
        end else begin
          enHold--;
        end
      end
      rstNow = (c >= 1000) && ($urandom_range(0, 99) < 2);
      clrNow = W'($urandom);
      applyStimulus(curI, curEn, rstNow, clrNow);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
